nes_controller_port: RTL and testbench

CPU-bus responder for the joypad registers at $4016/$4017: the far end of the CPU's address/data/rw bus and of its `out`/`oe` controller pins. It emulates two standard NES pads (4021-style 8-bit parallel-in/serial-out shift registers) from parallel button inputs. It returns serial button data to the CPU on reads and drives the OUT/OE pin images.

---
 rtl/nes_bus_pkg.sv | 21 ++
 rtl/nes_pad_shifter.sv | 45 ++++
 rtl/nes_controller_port.sv | 89 ++++++++
 tb/tb_nes_controller_port.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/nes_bus_pkg.sv
// Shared constants and types for the CPU-side joypad register block.
package nes_bus_pkg;

    localparam int unsigned PAD_W = 8;

    localparam logic [15:0] JOY1_ADDR        = 16'h4016;
    localparam logic [15:0] JOY2_ADDR        = 16'h4017;
    localparam logic [7:0]  OPEN_BUS_DEFAULT = 8'h40;

    typedef enum logic [2:0] {
        BTN_A,
        BTN_B,
        BTN_SELECT,
        BTN_START,
        BTN_UP,
        BTN_DOWN,
        BTN_LEFT,
        BTN_RIGHT
    } btn_idx_e;

endpackage

// File: rtl/nes_pad_shifter.sv
// One emulated 4021 pad: 2-flop button synchronizer feeding an 8-bit
// parallel-in/serial-out register that reloads while strobe is high.
module nes_pad_shifter
    import nes_bus_pkg::*;
#(
    parameter logic FILL_BIT = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             strobe,
    input  logic             shiftEn,
    input  logic [PAD_W-1:0] buttons,
    output logic             serialBit
);

    logic [PAD_W-1:0] sync1_q;
    logic [PAD_W-1:0] sync2_q;
    logic [PAD_W-1:0] shift_q;
    logic [PAD_W-1:0] shift_d;

    // Reload has priority over a pending shift while strobe is high.
    always_comb begin
        shift_d = shift_q;
        if (strobe) begin
            shift_d = sync2_q;
        end else if (shiftEn) begin
            shift_d = {FILL_BIT, shift_q[PAD_W-1:1]};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= buttons;
            sync2_q <= sync1_q;
            shift_q <= shift_d;
        end
    end

    assign serialBit = shift_q[0];

endmodule

// File: rtl/nes_controller_port.sv
// CPU-bus responder for $4016/$4017: two emulated pads, OUT pin latch and
// combinational read data / OE strobes for the current bus cycle.
module nes_controller_port
    import nes_bus_pkg::*;
#(
    parameter logic [7:0] OPEN_BUS = OPEN_BUS_DEFAULT,
    parameter logic       FILL_BIT = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             busValid,
    input  logic [15:0]      address,
    input  logic [7:0]       writeData,
    input  logic             rw,
    input  logic [PAD_W-1:0] buttons1,
    input  logic [PAD_W-1:0] buttons2,
    output logic [7:0]       readData,
    output logic             readHit,
    output logic [2:0]       out,
    output logic [1:0]       oe
);

    logic       hit1;
    logic       hit2;
    logic       wr_joy1;
    logic       ser1;
    logic       ser2;
    logic [2:0] out_q;
    logic [2:0] out_d;
    logic       unused_wdata;

    assign hit1    = busValid & rw & (address == JOY1_ADDR);
    assign hit2    = busValid & rw & (address == JOY2_ADDR);
    assign wr_joy1 = busValid & ~rw & (address == JOY1_ADDR);

    assign unused_wdata = ^writeData[7:3];

    always_comb begin
        out_d = out_q;
        if (wr_joy1) begin
            out_d = writeData[2:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q <= 3'b000;
        end else begin
            out_q <= out_d;
        end
    end

    nes_pad_shifter #(
        .FILL_BIT (FILL_BIT)
    ) u_pad1 (
        .clock     (clock),
        .reset     (reset),
        .strobe    (out_q[0]),
        .shiftEn   (hit1),
        .buttons   (buttons1),
        .serialBit (ser1)
    );

    nes_pad_shifter #(
        .FILL_BIT (FILL_BIT)
    ) u_pad2 (
        .clock     (clock),
        .reset     (reset),
        .strobe    (out_q[0]),
        .shiftEn   (hit2),
        .buttons   (buttons2),
        .serialBit (ser2)
    );

    // Bits 7:1 float to the open-bus value; only bit 0 carries pad data.
    always_comb begin
        readData = 8'h00;
        if (hit1) begin
            readData = {OPEN_BUS[7:1], ser1};
        end else if (hit2) begin
            readData = {OPEN_BUS[7:1], ser2};
        end
    end

    assign readHit = hit1 | hit2;
    assign oe      = {~hit2, ~hit1};
    assign out     = out_q;

endmodule

// File: tb/tb_nes_controller_port.sv
// Directed bench: every bus cycle queues its expected response; a negedge
// monitor pops and compares whenever a bus cycle is presented.
module tb_nes_controller_port;

    typedef struct packed {
        logic       hit;
        logic [7:0] data;
        logic [1:0] oe;
        logic [2:0] outp;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        busValid = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [7:0]  writeData = 8'h00;
    logic        rw = 1'b1;
    logic [7:0]  buttons1 = 8'h00;
    logic [7:0]  buttons2 = 8'h00;
    logic [7:0]  readData;
    logic        readHit;
    logic [2:0]  out;
    logic [1:0]  oe;

    exp_t        exp_q[$];
    logic [2:0]  exp_out = 3'b000;
    int          n_vec = 0;
    int          n_bad = 0;

    nes_controller_port dut (
        .clock     (clock),
        .reset     (reset),
        .busValid  (busValid),
        .address   (address),
        .writeData (writeData),
        .rw        (rw),
        .buttons1  (buttons1),
        .buttons2  (buttons2),
        .readData  (readData),
        .readHit   (readHit),
        .out       (out),
        .oe        (oe)
    );

    always #5 clock = ~clock;

    // Scoreboard monitor
    always @(negedge clock) begin
        if (reset && busValid) begin
            exp_t e;
            exp_t g;
            g = {readHit, readData, oe, out};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_cycle addr=%h got hit=%b data=%h oe=%b out=%b, required none queued",
                         address, g.hit, g.data, g.oe, g.outp);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL bus_cycle addr=%h rw=%b got hit=%b data=%h oe=%b out=%b, required hit=%b data=%h oe=%b out=%b",
                             address, rw, g.hit, g.data, g.oe, g.outp, e.hit, e.data, e.oe, e.outp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
        n_vec++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bus(input logic [15:0] a, input logic r, input logic [7:0] wd, input exp_t e);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        busValid  = 1'b1;
        address   = a;
        rw        = r;
        writeData = wd;
        @(posedge clock);
        #1;
        busValid  = 1'b0;
        rw        = 1'b1;
        writeData = 8'h00;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] wd);
        bus(a, 1'b0, wd, '{hit: 1'b0, data: 8'h00, oe: 2'b11, outp: exp_out});
        if (a == 16'h4016) exp_out = wd[2:0];
    endtask

    task automatic rd1(input logic b);
        bus(16'h4016, 1'b1, 8'h00, '{hit: 1'b1, data: {7'h20, b}, oe: 2'b10, outp: exp_out});
    endtask

    task automatic rd2(input logic b);
        bus(16'h4017, 1'b1, 8'h00, '{hit: 1'b1, data: {7'h20, b}, oe: 2'b01, outp: exp_out});
    endtask

    task automatic rdx(input logic [15:0] a);
        bus(a, 1'b1, 8'h00, '{hit: 1'b0, data: 8'h00, oe: 2'b11, outp: exp_out});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] seq1;

        // Reset state
        #12;
        check("reset_out", {5'b0, out}, 8'h00);
        check("reset_oe", {6'b0, oe}, 8'h03);
        check("reset_readData", readData, 8'h00);
        @(negedge clock);
        reset = 1'b1;
        idle(2);
        rd1(1'b0);

        // Latch and read pad 1
        buttons1 = 8'b1000_1001;
        idle(4);
        wr(16'h4016, 8'h01);
        wr(16'h4016, 8'h00);
        seq1 = 8'b1000_1001;
        for (int i = 0; i < 8; i++) rd1(seq1[i]);
        rd1(1'b1);
        rd1(1'b1);

        // Strobe held: reads track live A without shifting
        wr(16'h4016, 8'h01);
        buttons1 = 8'b1000_1000;
        idle(4);
        rd1(1'b0);
        buttons1 = 8'b1000_1001;
        idle(4);
        rd1(1'b1);
        rd1(1'b1);
        buttons1 = 8'b0000_0000;
        idle(4);
        rd1(1'b0);

        // Independent ports
        buttons1 = 8'hFF;
        buttons2 = 8'h02;
        idle(4);
        wr(16'h4016, 8'h00);
        rd2(1'b0);
        rd1(1'b1);
        rd2(1'b1);
        rd1(1'b1);

        // OUT pins and ignored $4017 writes
        wr(16'h4016, 8'hA5);
        wr(16'h4017, 8'hFF);
        wr(16'h4016, 8'hFA);
        wr(16'h4017, 8'hFF);
        rd2(1'b0);
        rd2(1'b1);

        // Non-hit reads leave shift state untouched
        buttons1 = 8'b0000_0010;
        wr(16'h4016, 8'h01);
        idle(4);
        wr(16'h4016, 8'h00);
        rd1(1'b0);
        rdx(16'h4015);
        rdx(16'h4018);
        rd1(1'b1);
        rd1(1'b0);

        // Reset mid-stream
        wr(16'h4016, 8'h03);
        idle(1);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_out", {5'b0, out}, 8'h00);
        check("midreset_oe", {6'b0, oe}, 8'h03);
        check("midreset_readData", readData, 8'h00);
        exp_out = 3'b000;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        idle(1);
        rd1(1'b0);

        idle(3);
        check("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
